// File: rtl/udp_pack_pkg.sv
// Shared send-FSM encoding and payload sizing helpers for the UDP payload packer.
// The optional sequence-word feature is selected with `UDP_PKT_SEQ_EN in the top.
package udp_pack_pkg;

    typedef enum logic [1:0] {
        SEND_IDLE  = 2'd0,
        SEND_START = 2'd1,
        SEND_DATA  = 2'd2
    } send_state_e;

    localparam int SEQ_WORD_BYTES = 4;

    function automatic logic [15:0] bytes_of(input int unsigned payload_words);
        return 16'(payload_words * 2);
    endfunction

endpackage

// File: rtl/udp_payload_packer_if.sv
// FIFO read-side and UDP TX handshake signals of the payload packer.
// master = the packer, slave = the FIFO / UDP TX environment.
interface udp_payload_packer_if;

    logic        fifo_rd_en;
    logic        fifo_rd_vld;
    logic [15:0] fifo_rd_data;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        tx_done;
    logic [15:0] pkt_cnt;
    logic        busy;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_vld, fifo_rd_data,
        output tx_start_en, tx_byte_num,
        input  tx_req,
        output tx_data,
        input  tx_done,
        output pkt_cnt, busy
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_vld, fifo_rd_data,
        input  tx_start_en, tx_byte_num,
        output tx_req,
        input  tx_data,
        output tx_done,
        input  pkt_cnt, busy
    );

endinterface

// File: rtl/udp_pingpong_ram.sv
// Simple dual-port 32-bit RAM holding both ping-pong banks; address MSB selects the bank.
// One write port, one read port with a single registered read stage.
module udp_pingpong_ram #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/udp_payload_packer.sv
// Packs 16-bit FIFO words big-endian into 32-bit ping-pong banks and hands each full bank
// to the UDP TX stack as one payload. `UDP_PKT_SEQ_EN prepends a 32-bit sequence word.
module udp_payload_packer
    import udp_pack_pkg::*;
#(
    parameter int PAYLOAD_WORDS = 512,
    parameter int BANK_AW       = 8,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    udp_payload_packer_if.master bus
);

    localparam logic [BANK_AW-1:0] LAST_ADDR = BANK_AW'(PAYLOAD_WORDS / 2 - 1);
`ifdef UDP_PKT_SEQ_EN
    localparam logic [15:0] BYTE_NUM = bytes_of(PAYLOAD_WORDS) + 16'(SEQ_WORD_BYTES);
`else
    localparam logic [15:0] BYTE_NUM = bytes_of(PAYLOAD_WORDS);
`endif

    // Fill path state
    logic               fill_bank;
    logic               half;
    logic [15:0]        hi_word;
    logic [BANK_AW-1:0] wr_addr;
    logic [1:0]         bank_full;

    // Send path state
    send_state_e        state;
    logic               send_bank;
    logic [BANK_AW-1:0] rd_addr;
    logic [15:0]        gap_cnt;
    logic [15:0]        pkt_cnt;
    logic               tx_start_en;
    logic [15:0]        tx_byte_num;
    logic [31:0]        ram_rdata;

    logic pop, ram_we, ram_re, fill_done, send_release, seq_slot;
    logic [1:0] set_mask, clr_mask;

`ifdef UDP_PKT_SEQ_EN
    logic [31:0] seq_num;
    logic        seq_pending;
    logic        seq_sel;
    assign seq_slot    = seq_pending;
    assign bus.tx_data = seq_sel ? seq_num : ram_rdata;
`else
    assign seq_slot    = 1'b0;
    assign bus.tx_data = ram_rdata;
`endif

    assign pop          = bus.fifo_rd_vld & ~bank_full[fill_bank];
    assign ram_we       = pop & half;
    assign fill_done    = ram_we && (wr_addr == LAST_ADDR);
    assign send_release = (state == SEND_DATA) && bus.tx_done;
    assign ram_re       = (state == SEND_DATA) && bus.tx_req && !seq_slot;

    assign bus.fifo_rd_en  = pop;
    assign bus.tx_start_en = tx_start_en;
    assign bus.tx_byte_num = tx_byte_num;
    assign bus.pkt_cnt     = pkt_cnt;
    assign bus.busy        = (state != SEND_IDLE);

    always_comb begin
        // NOTE: defaults first so every path assigns both masks and no latch is inferred.
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (fill_done)    set_mask[fill_bank] = 1'b1;
        if (send_release) clr_mask[send_bank] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            fill_bank <= 1'b0;
            half      <= 1'b0;
            hi_word   <= '0;
            wr_addr   <= '0;
            bank_full <= '0;
        end else begin
            // Fill sets and send clears always target different banks.
            bank_full <= (bank_full & ~clr_mask) | set_mask;
            if (pop && !half) begin
                hi_word <= bus.fifo_rd_data;
                half    <= 1'b1;
            end else if (pop) begin
                half <= 1'b0;
                if (wr_addr == LAST_ADDR) begin
                    wr_addr   <= '0;
                    fill_bank <= ~fill_bank;
                end else begin
                    wr_addr <= wr_addr + BANK_AW'(1);
                end
            end
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state       <= SEND_IDLE;
            send_bank   <= 1'b0;
            rd_addr     <= '0;
            gap_cnt     <= '0;
            pkt_cnt     <= '0;
            tx_start_en <= 1'b0;
            tx_byte_num <= '0;
`ifdef UDP_PKT_SEQ_EN
            seq_num     <= '0;
            seq_pending <= 1'b0;
            seq_sel     <= 1'b0;
`endif
        end else begin
            tx_start_en <= 1'b0;
            case (state)
                SEND_IDLE: begin
                    if (gap_cnt != 16'd0) begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end else if (bank_full[send_bank]) begin
                        state       <= SEND_START;
                        tx_start_en <= 1'b1;
                        tx_byte_num <= BYTE_NUM;
`ifdef UDP_PKT_SEQ_EN
                        seq_pending <= 1'b1;
`endif
                    end
                end
                SEND_START: state <= SEND_DATA;
                SEND_DATA: begin
`ifdef UDP_PKT_SEQ_EN
                    if (bus.tx_req) begin
                        seq_sel     <= seq_pending;
                        seq_pending <= 1'b0;
                    end
`endif
                    // Extra requests past the end keep re-reading the last word.
                    if (ram_re && rd_addr != LAST_ADDR) rd_addr <= rd_addr + BANK_AW'(1);
                    if (bus.tx_done) begin
                        send_bank <= ~send_bank;
                        rd_addr   <= '0;
                        pkt_cnt   <= pkt_cnt + 16'd1;
                        gap_cnt   <= 16'(GAP_CYCLES);
                        state     <= SEND_IDLE;
`ifdef UDP_PKT_SEQ_EN
                        seq_num   <= seq_num + 32'd1;
`endif
                    end
                end
                default: state <= SEND_IDLE;
            endcase
        end
    end

    udp_pingpong_ram #(
        .AW (BANK_AW + 1)
    ) u_ram (
        .clk   (rd_clk),
        .rst   (rd_rst),
        .we    (ram_we),
        .waddr ({fill_bank, wr_addr}),
        .wdata ({hi_word, bus.fifo_rd_data}),
        .re    (ram_re),
        .raddr ({send_bank, rd_addr}),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_udp_payload_packer.sv
// Self-checking bench for udp_payload_packer (PAYLOAD_WORDS=8, GAP_CYCLES=4); honours `UDP_PKT_SEQ_EN.
// Expected payloads come from the pushed word stream: packet p is words 8p..8p+7 paired big-endian.
module tb_udp_payload_packer;

    localparam int PW  = 8;
    localparam int GAP = 4;
    localparam int WPP = PW / 2;
`ifdef UDP_PKT_SEQ_EN
    localparam bit SEQ_EN    = 1'b1;
    localparam int EXP_BYTES = PW * 2 + 4;
`else
    localparam bit SEQ_EN    = 1'b0;
    localparam int EXP_BYTES = PW * 2;
`endif

    logic rd_clk = 1'b0;
    logic rd_rst;

    udp_payload_packer_if bus();

    udp_payload_packer #(
        .PAYLOAD_WORDS (PW),
        .BANK_AW       (2),
        .GAP_CYCLES    (GAP)
    ) dut (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .bus    (bus.master)
    );

    always #5 rd_clk = ~rd_clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] src_mem [0:4095];
    int src_wr, src_rd, n_start, n_served, cyc, done_cyc, start_cyc;
    bit vld_gap, rand_gap, pop_now;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        bus.fifo_rd_vld  = (src_rd < src_wr) && !vld_gap;
        bus.fifo_rd_data = (src_rd < src_wr) ? src_mem[src_rd[11:0]] : 16'h0000;
    endtask

    task automatic push(input logic [15:0] w);
        src_mem[src_wr[11:0]] = w;
        src_wr++;
        drive_src();
    endtask

    // One clock: pops are sampled at the falling edge, results observed 1 unit after the rising edge.
    task automatic cycle();
        @(negedge rd_clk);
        pop_now = bus.fifo_rd_vld && bus.fifo_rd_en;
        @(posedge rd_clk);
        #1;
        cyc++;
        if (pop_now) src_rd++;
        bus.tx_req  = 1'b0;
        bus.tx_done = 1'b0;
        vld_gap = rand_gap && ($urandom_range(0, 3) == 0);
        drive_src();
        if (bus.tx_start_en) begin
            n_start++;
            start_cyc = cyc;
        end
    endtask

    task automatic clear_model();
        src_wr   = 0;
        src_rd   = 0;
        n_start  = 0;
        n_served = 0;
        vld_gap  = 1'b0;
        drive_src();
    endtask

    task automatic do_reset();
        rd_rst      = 1'b1;
        bus.tx_req  = 1'b0;
        bus.tx_done = 1'b0;
        clear_model();
        repeat (3) cycle();
        rd_rst = 1'b0;
        cycle();
    endtask

    function automatic logic [31:0] expected(input int p, input int r);
        int j;
        int idx;
        j = r;
        if (SEQ_EN) begin
            if (r == 0) return 32'(p);
            j = r - 1;
        end
        if (j > WPP - 1) j = WPP - 1;
        idx = p * PW + 2 * j;
        return {src_mem[idx[11:0]], src_mem[idx[11:0] + 12'd1]};
    endfunction

    task automatic wait_start(input int budget);
        int n = 0;
        while (n_start <= n_served && n < budget) begin
            cycle();
            n++;
        end
        check("start_seen", 32'(n_start > n_served), 32'd1);
    endtask

    task automatic issue_req(input int p, input int r);
        logic [31:0] exp;
        repeat ($urandom_range(0, 2)) cycle();
        bus.tx_req = 1'b1;
        cycle();
        exp = expected(p, r);
        check("tx_data", bus.tx_data, exp);
        repeat ($urandom_range(0, 2)) cycle();
        check("tx_data_hold", bus.tx_data, exp);
    endtask

    task automatic begin_packet();
        wait_start(200);
        check("byte_num", 32'(bus.tx_byte_num), 32'(EXP_BYTES));
        if (n_served > 0) check("gap_after_done", 32'((start_cyc - done_cyc) >= GAP), 32'd1);
        cycle();
        check("start_one_cycle", 32'(bus.tx_start_en), 32'd0);
        check("byte_num_held", 32'(bus.tx_byte_num), 32'(EXP_BYTES));
        check("busy_send", 32'(bus.busy), 32'd1);
    endtask

    task automatic serve_packet(input int nreq);
        int p;
        p = n_served;
        begin_packet();
        for (int r = 0; r < nreq; r++) issue_req(p, r);
        bus.tx_done = 1'b1;
        cycle();
        done_cyc = cyc;
        n_served++;
        check("pkt_cnt", 32'(bus.pkt_cnt), 32'(n_served[15:0]));
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},    32'(bus.fifo_rd_en),  32'd0);
        check({tag, "_start"},    32'(bus.tx_start_en), 32'd0);
        check({tag, "_byte_num"}, 32'(bus.tx_byte_num), 32'd0);
        check({tag, "_tx_data"},  bus.tx_data,          32'd0);
        check({tag, "_pkt_cnt"},  32'(bus.pkt_cnt),     32'd0);
        check({tag, "_busy"},     32'(bus.busy),        32'd0);
    endtask

    initial begin
        cyc      = 0;
        done_cyc = 0;
        rand_gap = 1'b0;
        do_reset();
        check_outputs_zero("reset");

        // Counting pattern: one packet, four requests, then tx_done.
        for (int i = 1; i <= 8; i++) push(16'(i));
        serve_packet(WPP + (SEQ_EN ? 1 : 0));

        // Seven words must not start a packet; the eighth after an idle gap does.
        for (int i = 0; i < 7; i++) push(16'($urandom));
        repeat (12) cycle();
        check("no_start_7_words", 32'(n_start), 32'(n_served));
        push(16'($urandom));
        serve_packet(WPP + 1);

        // Reset mid-run with a packet started and a half word pending.
        for (int i = 0; i < 11; i++) push(16'($urandom));
        wait_start(200);
        rd_rst = 1'b1;
        clear_model();
        #1;
        check_outputs_zero("mid_reset");
        cycle();
        cycle();
        rd_rst = 1'b0;
        cycle();
        check_outputs_zero("post_reset");
        push(16'hA5A5);
        #1;
        check("rd_en_on_vld", 32'(bus.fifo_rd_en), 32'd1);
        do_reset();

        // Backpressure: both banks fill, the rest waits in the FIFO.
        for (int i = 0; i < 24; i++) push(16'($urandom));
        repeat (40) cycle();
        check("pops_two_banks", 32'(src_rd), 32'd16);
        check("rd_en_both_full", 32'(bus.fifo_rd_en), 32'd0);
        serve_packet(WPP);
        serve_packet(WPP + (SEQ_EN ? 1 : 0));
        serve_packet(WPP + 2);

        // Reset during SEND after two requests; the next packet holds only fresh data.
        do_reset();
        for (int i = 0; i < 8; i++) push(16'($urandom));
        begin_packet();
        issue_req(0, 0);
        issue_req(0, 1);
        rd_rst = 1'b1;
        clear_model();
        #1;
        check("send_reset_busy", 32'(bus.busy), 32'd0);
        cycle();
        rd_rst = 1'b0;
        repeat (10) cycle();
        check("banks_empty", 32'(n_start), 32'd0);
        for (int i = 0; i < 8; i++) push(16'($urandom));
        serve_packet(WPP + (SEQ_EN ? 1 : 0));
        serve_check_done: check("pkt_cnt_after_reset", 32'(bus.pkt_cnt), 32'd1);

        // Randomized traffic with valid gaps, random request spacing and extra requests.
        rand_gap = 1'b1;
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(6, 20);
            for (int i = 0; i < n; i++) push(16'($urandom));
            repeat ($urandom_range(0, 30)) cycle();
            while ((src_wr / PW) > n_served) serve_packet($urandom_range(WPP, WPP + 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
